// File: rtl/ip_mapperram_pkg.sv
// Shared types and helpers for the MSX memory-mapper RAM controller.
// Segment values travel through the helpers at full 8-bit width and are truncated by the caller.
package ip_mapperram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  function automatic logic [7:0] page_dec(
    input logic [1:0] page,
    input logic [7:0] seg0,
    input logic [7:0] seg1,
    input logic [7:0] seg2,
    input logic [7:0] seg3
  );
    logic [7:0] seg;
    case (page)
      2'd0:    seg = seg0;
      2'd1:    seg = seg1;
      2'd2:    seg = seg2;
      default: seg = seg3;
    endcase
    return seg;
  endfunction

  // Unimplemented upper segment bits read back as ones, as on real MSX mappers.
  function automatic logic [7:0] readback_pad(input logic [7:0] seg, input int seg_bits);
    logic [7:0] padded;
    for (int i = 0; i < 8; i++) begin
      padded[i] = (i < seg_bits) ? seg[i] : 1'b1;
    end
    return padded;
  endfunction

endpackage

// File: rtl/ip_mapperram_ex_if.sv
// Bundles the MSX-50BUS slave side and the RAM arbiter side of the mapper.
// The mapper is the slave; whoever drives the bus and serves the RAM port is the master.
interface ip_mapperram_ex_if #(
  parameter int SEG_BITS = 8
);

  logic [15:0]           bus_address;
  logic [7:0]            bus_write_data;
  logic                  bus_io_read;
  logic                  bus_io_write;
  logic                  bus_memory_read;
  logic                  bus_memory_write;
  logic                  bus_read_ready;
  logic [7:0]            bus_read_data;
  logic                  rd;
  logic                  wr;
  logic                  busy;
  logic [SEG_BITS+13:0]  address;
  logic [7:0]            wdata;
  logic [7:0]            rdata;
  logic                  rdata_en;

  modport slave (
    input  bus_address, bus_write_data, bus_io_read, bus_io_write,
    input  bus_memory_read, bus_memory_write, busy, rdata, rdata_en,
    output bus_read_ready, bus_read_data, rd, wr, address, wdata
  );

  modport master (
    output bus_address, bus_write_data, bus_io_read, bus_io_write,
    output bus_memory_read, bus_memory_write, busy, rdata, rdata_en,
    input  bus_read_ready, bus_read_data, rd, wr, address, wdata
  );

endinterface

// File: rtl/ip_mapperram_segregs.sv
// The four page segment registers with their I/O write decode and registered readback.
// Readback data appears one cycle after the I/O read edge and lasts one cycle.
module ip_mapperram_segregs
  import ip_mapperram_pkg::*;
#(
  parameter int          SEG_BITS = 8,
  parameter logic [7:0]  IO_BASE  = 8'hFC,
  parameter int          READBACK = 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     io_write,
  input  logic                     io_read_edge,
  input  logic [7:0]               io_addr,
  input  logic [7:0]               io_wdata,
  output logic [3:0][SEG_BITS-1:0] segs,
  output logic                     rb_valid,
  output logic [7:0]               rb_data
);

  logic       port_hit;
  logic [7:0] selected_seg;

  // IO_BASE is 4-aligned, so the upper six bits pick the block and the low two the page.
  assign port_hit     = (io_addr[7:2] == IO_BASE[7:2]);
  assign selected_seg = 8'(segs[io_addr[1:0]]);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int n = 0; n < 4; n++) begin
        segs[n] <= SEG_BITS'(3 - n);
      end
    end else if (io_write && port_hit) begin
      segs[io_addr[1:0]] <= io_wdata[SEG_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rb_valid <= 1'b0;
      rb_data  <= 8'd0;
    end else begin
      rb_valid <= (READBACK != 0) && io_read_edge && port_hit;
      rb_data  <= readback_pad(selected_seg, SEG_BITS);
    end
  end

endmodule

// File: rtl/ip_mapperram_ex.sv
// MSX memory-mapper RAM controller: strobe edge detection, segment translation and a
// request FSM that holds the latched request until the RAM arbiter drops busy.
module ip_mapperram_ex
  import ip_mapperram_pkg::*;
#(
  parameter int          SEG_BITS = 8,
  parameter logic [7:0]  IO_BASE  = 8'hFC,
  parameter int          READBACK = 1
) (
  input  logic                clk,
  input  logic                n_reset,
  ip_mapperram_ex_if.slave    bus,
  output logic                overrun
);

  logic                     mem_read_q;
  logic                     mem_write_q;
  logic                     io_read_q;
  logic                     mem_read_edge;
  logic                     mem_write_edge;
  logic                     io_read_edge;
  logic                     mem_edge;
  state_t                   state;
  state_t                   state_next;
  logic                     is_write;
  logic                     mem_done;
  logic [3:0][SEG_BITS-1:0] segs;
  logic                     rb_valid;
  logic [7:0]               rb_data;
  logic [7:0]               page_seg;
  logic [SEG_BITS-1:0]      seg_sel;

  assign mem_read_edge  = bus.bus_memory_read  && !mem_read_q;
  assign mem_write_edge = bus.bus_memory_write && !mem_write_q;
  assign io_read_edge   = bus.bus_io_read      && !io_read_q;
  assign mem_edge       = mem_read_edge || mem_write_edge;

  assign page_seg = page_dec(bus.bus_address[15:14],
                             8'(segs[0]), 8'(segs[1]), 8'(segs[2]), 8'(segs[3]));
  assign seg_sel  = page_seg[SEG_BITS-1:0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      io_read_q   <= 1'b0;
    end else begin
      mem_read_q  <= bus.bus_memory_read;
      mem_write_q <= bus.bus_memory_write;
      io_read_q   <= bus.bus_io_read;
    end
  end

  ip_mapperram_segregs #(
    .SEG_BITS (SEG_BITS),
    .IO_BASE  (IO_BASE),
    .READBACK (READBACK)
  ) u_segregs (
    .clk          (clk),
    .n_reset      (n_reset),
    .io_write     (bus.bus_io_write),
    .io_read_edge (io_read_edge),
    .io_addr      (bus.bus_address[7:0]),
    .io_wdata     (bus.bus_write_data),
    .segs         (segs),
    .rb_valid     (rb_valid),
    .rb_data      (rb_data)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (mem_edge)      state_next = ISSUE;
      ISSUE:     if (!bus.busy)     state_next = is_write ? IDLE : WAIT_DATA;
      WAIT_DATA: if (bus.rdata_en)  state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Memory completion beats a coincident I/O readback; the bus never produces both at once.
  always_comb begin
    bus.rd             = 1'b0;
    bus.wr             = 1'b0;
    mem_done           = 1'b0;
    case (state)
      ISSUE: begin
        bus.rd = !bus.busy && !is_write;
        bus.wr = !bus.busy &&  is_write;
      end
      WAIT_DATA: mem_done = bus.rdata_en;
      default: ;
    endcase
    bus.bus_read_ready = mem_done || rb_valid;
    if (mem_done) begin
      bus.bus_read_data = bus.rdata;
    end else if (rb_valid) begin
      bus.bus_read_data = rb_data;
    end else begin
      bus.bus_read_data = 8'd0;
    end
  end

  // Request capture happens only in IDLE, so later segment writes never disturb a pending access.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.address <= '0;
      bus.wdata   <= 8'd0;
      is_write    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (state == IDLE && mem_edge) begin
        bus.address <= {seg_sel, bus.bus_address[13:0]};
        bus.wdata   <= bus.bus_write_data;
        is_write    <= mem_write_edge;
      end
      if ((state != IDLE && mem_edge) || (state == IDLE && mem_read_edge && mem_write_edge)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ip_mapperram_ex.sv
// Scoreboard bench for ip_mapperram_ex: a default instance and a SEG_BITS=4 / IO_BASE=F8 instance.
// Expected RAM requests and read returns are queued when driven and popped when the DUT emits them.
module tb_ip_mapperram_ex;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } req_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       sel = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       mrd = 1'b0;
  logic       mwr = 1'b0;
  logic       iord = 1'b0;
  logic       iowr = 1'b0;
  logic       busy = 1'b0;
  logic [7:0] rdata = '0;
  logic       rdata_en = 1'b0;
  logic       overrun_a;
  logic       overrun_b;
  int         cyc = 0;
  int         checks_total = 0;
  int         checks_passed = 0;

  req_t req_qa[$];
  req_t req_qb[$];
  rsp_t rsp_qa[$];
  rsp_t rsp_qb[$];
  req_t ea;
  req_t eb;
  rsp_t ra;
  rsp_t rb;

  ip_mapperram_ex_if #(.SEG_BITS(8)) bus_a ();
  ip_mapperram_ex_if #(.SEG_BITS(4)) bus_b ();

  assign bus_a.bus_address      = addr;
  assign bus_a.bus_write_data   = wdata;
  assign bus_a.bus_memory_read  = !sel && mrd;
  assign bus_a.bus_memory_write = !sel && mwr;
  assign bus_a.bus_io_read      = !sel && iord;
  assign bus_a.bus_io_write     = !sel && iowr;
  assign bus_a.busy             = !sel && busy;
  assign bus_a.rdata            = rdata;
  assign bus_a.rdata_en         = !sel && rdata_en;

  assign bus_b.bus_address      = addr;
  assign bus_b.bus_write_data   = wdata;
  assign bus_b.bus_memory_read  = sel && mrd;
  assign bus_b.bus_memory_write = sel && mwr;
  assign bus_b.bus_io_read      = sel && iord;
  assign bus_b.bus_io_write     = sel && iowr;
  assign bus_b.busy             = sel && busy;
  assign bus_b.rdata            = rdata;
  assign bus_b.rdata_en         = sel && rdata_en;

  ip_mapperram_ex #(.SEG_BITS(8), .IO_BASE(8'hFC), .READBACK(1)) dut_a (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus_a),
    .overrun (overrun_a)
  );

  ip_mapperram_ex #(.SEG_BITS(4), .IO_BASE(8'hF8), .READBACK(1)) dut_b (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus_b),
    .overrun (overrun_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end else begin
      checks_passed++;
    end
  endtask

  // Requests and read returns are checked here, away from the active edge.
  always @(negedge clk) begin
    if (bus_a.rd || bus_a.wr) begin
      if (req_qa.size() == 0) begin
        checkOutput("a_unexpected_req", {30'd0, bus_a.wr, bus_a.rd}, 32'd0);
      end else begin
        ea = req_qa.pop_front();
        checkOutput("a_req_wr", 32'(bus_a.wr), 32'(ea.is_wr));
        checkOutput("a_req_rd", 32'(bus_a.rd), 32'(!ea.is_wr));
        checkOutput("a_req_addr", 32'(bus_a.address), ea.addr);
        if (ea.is_wr) checkOutput("a_req_wdata", 32'(bus_a.wdata), 32'(ea.data));
        checkOutput("a_req_cycle", cyc, ea.cyc);
      end
    end
    if (bus_a.bus_read_ready) begin
      if (rsp_qa.size() == 0) begin
        checkOutput("a_unexpected_ready", 32'(bus_a.bus_read_ready), 32'd0);
      end else begin
        ra = rsp_qa.pop_front();
        checkOutput("a_rsp_data", 32'(bus_a.bus_read_data), 32'(ra.data));
        checkOutput("a_rsp_cycle", cyc, ra.cyc);
      end
    end else if (bus_a.bus_read_data !== 8'd0) begin
      checkOutput("a_data_not_ready", 32'(bus_a.bus_read_data), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus_b.rd || bus_b.wr) begin
      if (req_qb.size() == 0) begin
        checkOutput("b_unexpected_req", {30'd0, bus_b.wr, bus_b.rd}, 32'd0);
      end else begin
        eb = req_qb.pop_front();
        checkOutput("b_req_wr", 32'(bus_b.wr), 32'(eb.is_wr));
        checkOutput("b_req_rd", 32'(bus_b.rd), 32'(!eb.is_wr));
        checkOutput("b_req_addr", 32'(bus_b.address), eb.addr);
        if (eb.is_wr) checkOutput("b_req_wdata", 32'(bus_b.wdata), 32'(eb.data));
        checkOutput("b_req_cycle", cyc, eb.cyc);
      end
    end
    if (bus_b.bus_read_ready) begin
      if (rsp_qb.size() == 0) begin
        checkOutput("b_unexpected_ready", 32'(bus_b.bus_read_ready), 32'd0);
      end else begin
        rb = rsp_qb.pop_front();
        checkOutput("b_rsp_data", 32'(bus_b.bus_read_data), 32'(rb.data));
        checkOutput("b_rsp_cycle", cyc, rb.cyc);
      end
    end else if (bus_b.bus_read_data !== 8'd0) begin
      checkOutput("b_data_not_ready", 32'(bus_b.bus_read_data), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushReq(input bit is_wr, input logic [31:0] exp_addr, input logic [7:0] d, input int exp_cyc);
    req_t e;
    e.is_wr = is_wr;
    e.addr  = exp_addr;
    e.data  = d;
    e.cyc   = exp_cyc;
    if (sel) req_qb.push_back(e);
    else     req_qa.push_back(e);
  endtask

  task automatic pushRsp(input logic [7:0] d, input int exp_cyc);
    rsp_t r;
    r.data = d;
    r.cyc  = exp_cyc;
    if (sel) rsp_qb.push_back(r);
    else     rsp_qa.push_back(r);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (req_qa.size() + req_qb.size() + rsp_qa.size() + rsp_qb.size() == 0) return;
      @(negedge clk);
    end
    checkOutput(tag, req_qa.size() + req_qb.size() + rsp_qa.size() + rsp_qb.size(), 0);
    req_qa.delete();
    req_qb.delete();
    rsp_qa.delete();
    rsp_qb.delete();
  endtask

  task automatic rdataPulse(input logic [7:0] v);
    step();
    rdata    = v;
    rdata_en = 1'b1;
    pushRsp(v, cyc);
    step();
    rdata_en = 1'b0;
    waitDrain("rsp_timeout");
  endtask

  task automatic ioWrite(input logic [7:0] port, input logic [7:0] d);
    addr  = {8'h00, port};
    wdata = d;
    iowr  = 1'b1;
    step();
    iowr  = 1'b0;
    step();
  endtask

  task automatic ioRead(input logic [7:0] port, input logic [7:0] expected);
    addr = {8'h00, port};
    iord = 1'b1;
    pushRsp(expected, cyc + 1);
    step();
    step();
    iord = 1'b0;
    waitDrain("io_rsp_timeout");
    step();
  endtask

  // One memory access from edge to completion; busy is held through cycles 1..busy_k.
  task automatic applyStimulus(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                               input int busy_k, input logic [31:0] exp_addr, input logic [7:0] rdv);
    addr  = a;
    wdata = d;
    busy  = (busy_k > 0);
    if (is_wr) mwr = 1'b1;
    else       mrd = 1'b1;
    pushReq(is_wr, exp_addr, d, cyc + 1 + busy_k);
    if (busy_k > 0) begin
      repeat (busy_k + 1) step();
      busy = 1'b0;
    end
    waitDrain("req_timeout");
    step();
    mrd = 1'b0;
    mwr = 1'b0;
    if (!is_wr) rdataPulse(rdv);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed so far", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) step();
    checkOutput("rst_a_rd", 32'(bus_a.rd), 0);
    checkOutput("rst_a_wr", 32'(bus_a.wr), 0);
    checkOutput("rst_a_ready", 32'(bus_a.bus_read_ready), 0);
    checkOutput("rst_a_data", 32'(bus_a.bus_read_data), 0);
    checkOutput("rst_a_address", 32'(bus_a.address), 0);
    checkOutput("rst_a_wdata", 32'(bus_a.wdata), 0);
    checkOutput("rst_a_overrun", 32'(overrun_a), 0);
    checkOutput("rst_b_address", 32'(bus_b.address), 0);
    n_reset = 1'b1;
    step();

    $display("[TB] default instance: read, busy write, overrun");
    applyStimulus(1'b0, 16'h4000, 8'h00, 0, 32'h08000, 8'h3C);
    ioWrite(8'hFE, 8'h05);
    applyStimulus(1'b1, 16'h8123, 8'hA5, 3, 32'h14123, 8'h00);
    ioRead(8'hFE, 8'h05);

    addr = 16'h0000;
    mrd  = 1'b1;
    pushReq(1'b0, 32'h0C000, 8'h00, cyc + 1);
    waitDrain("ovr_req_timeout");
    step();
    checkOutput("a_overrun_clear", 32'(overrun_a), 0);
    addr  = 16'hC000;
    wdata = 8'h11;
    mwr   = 1'b1;
    step();
    step();
    checkOutput("a_overrun_set", 32'(overrun_a), 1);
    rdataPulse(8'h5A);
    step();
    step();
    mrd = 1'b0;
    mwr = 1'b0;
    step();
    checkOutput("a_overrun_sticky", 32'(overrun_a), 1);

    $display("[TB] SEG_BITS=4, IO_BASE=F8 instance");
    sel = 1'b1;
    step();
    ioWrite(8'hF8, 8'hFF);
    ioRead(8'hF8, 8'hFF);
    ioWrite(8'hF8, 8'h13);
    ioRead(8'hF8, 8'hF3);
    ioWrite(8'hFC, 8'h09);
    ioRead(8'hF8, 8'hF3);
    ioRead(8'hF9, 8'hF2);
    ioWrite(8'hF8, 8'h07);
    applyStimulus(1'b0, 16'h0010, 8'h00, 0, 32'h1C010, 8'h77);
    checkOutput("b_overrun_clear", 32'(overrun_b), 0);
    sel = 1'b0;
    step();

    $display("[TB] reset while a request waits on busy");
    addr = 16'h4ABC;
    busy = 1'b1;
    mrd  = 1'b1;
    step();
    step();
    checkOutput("pre_rst_a_address", 32'(bus_a.address), 32'h08ABC);
    n_reset = 1'b0;
    busy    = 1'b0;
    mrd     = 1'b0;
    #1;
    checkOutput("mid_rst_a_rd", 32'(bus_a.rd), 0);
    checkOutput("mid_rst_a_wr", 32'(bus_a.wr), 0);
    checkOutput("mid_rst_a_ready", 32'(bus_a.bus_read_ready), 0);
    checkOutput("mid_rst_a_data", 32'(bus_a.bus_read_data), 0);
    checkOutput("mid_rst_a_address", 32'(bus_a.address), 0);
    checkOutput("mid_rst_a_wdata", 32'(bus_a.wdata), 0);
    checkOutput("mid_rst_a_overrun", 32'(overrun_a), 0);
    repeat (3) step();
    n_reset = 1'b1;
    step();
    ioRead(8'hFC, 8'h03);
    ioRead(8'hFD, 8'h02);
    ioRead(8'hFE, 8'h01);
    ioRead(8'hFF, 8'h00);
    sel = 1'b1;
    step();
    ioRead(8'hF9, 8'hF2);
    sel = 1'b0;
    step();

    $display("[TB] simultaneous read and write edges");
    addr  = 16'h4001;
    wdata = 8'h66;
    mrd   = 1'b1;
    mwr   = 1'b1;
    pushReq(1'b1, 32'h08001, 8'h66, cyc + 1);
    waitDrain("both_req_timeout");
    step();
    checkOutput("a_overrun_both", 32'(overrun_a), 1);
    mrd = 1'b0;
    mwr = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
